dca_lsu_row_packer: RTL

DCA_LSU_ROW_PACKER -- requirements
Module: dca_lsu_row_packer

---
 rtl/dca_lsu_row_packer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dca_lsu_row_packer.sv
// dca_lsu_row_packer: converts LSU rows to 32-bit-per-column slots and
// packs ROWS_PER_BEAT of them into output beats through a 2-entry FIFO.
module dca_lsu_row_packer #(
    parameter int NUM_COL       = 4,
    parameter int BW_ELEMENT    = 32,
    parameter int ROWS_PER_BEAT = 2,
    parameter int BW_TXN_INFO   = 8
) (
    input  logic                                  clk,
    input  logic                                  rstnn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BW_ELEMENT*NUM_COL-1:0]         in_data,
    input  logic [2:0]                            in_size,
    input  logic                                  in_signed,
    input  logic [NUM_COL-1:0]                    in_col_mask,
    input  logic                                  in_last,
    input  logic [BW_TXN_INFO-1:0]                in_txn_info,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [32*NUM_COL*ROWS_PER_BEAT-1:0]   out_data,
    output logic [ROWS_PER_BEAT-1:0]              out_row_valid,
    output logic                                  out_last,
    output logic [BW_TXN_INFO-1:0]                out_txn_info,
    output logic                                  busy
);

    localparam int BW_SLOT = 32 * NUM_COL;
    localparam int BW_OUT  = BW_SLOT * ROWS_PER_BEAT;
    localparam int CW      = (ROWS_PER_BEAT > 1) ? $clog2(ROWS_PER_BEAT) : 1;
    localparam int EW      = 1 + BW_TXN_INFO + ROWS_PER_BEAT + BW_OUT;

    logic [NUM_COL-1:0][31:0]                ext;
    logic [BW_SLOT-1:0]                      row;
    logic [ROWS_PER_BEAT-1:0][BW_SLOT-1:0]   asm_data;
    logic [ROWS_PER_BEAT-1:0]                asm_rv;
    logic [CW-1:0]                           cnt;
    logic [ROWS_PER_BEAT-1:0][BW_SLOT-1:0]   beat_data;
    logic [ROWS_PER_BEAT-1:0]                beat_rv;
    logic [EW-1:0]                           q0;
    logic [EW-1:0]                           q1;
    logic [EW-1:0]                           new_entry;
    logic [1:0]                              count;
    logic                                    acc;
    logic                                    close;
    logic                                    push;
    logic                                    pop;

    // Widen every element to 32 bits (sign or zero) and apply the column mask
    always_comb begin
        ext = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            ext[c] = {32{in_signed & in_data[BW_ELEMENT*c + BW_ELEMENT-1]}};
            ext[c][BW_ELEMENT-1:0] = in_data[BW_ELEMENT*c +: BW_ELEMENT];
            if (!in_col_mask[c]) begin
                ext[c] = '0;
            end
        end
    end

    // One candidate slot layout per packed width; the low W bits of the
    // widened element are exactly the truncated or extended field
    for (genvar s = 0; s < 6; s++) begin : g_sz
        localparam int W = 1 << s;
        logic [BW_SLOT-1:0] cand;

        // Place each column field at W*c with zero fill above
        always_comb begin
            cand = '0;
            for (int c = 0; c < NUM_COL; c++) begin
                cand[W*c +: W] = ext[c][W-1:0];
            end
        end
    end

    // Pick the layout for the requested size; sizes 5..7 all mean 32 bits
    always_comb begin
        case (in_size)
            3'd0:    row = g_sz[0].cand;
            3'd1:    row = g_sz[1].cand;
            3'd2:    row = g_sz[2].cand;
            3'd3:    row = g_sz[3].cand;
            3'd4:    row = g_sz[4].cand;
            default: row = g_sz[5].cand;
        endcase
    end

    assign acc   = in_valid && in_ready;
    assign close = in_last || (cnt == CW'(ROWS_PER_BEAT-1));
    assign push  = acc && close;
    assign pop   = out_valid && out_ready;

    // Beat contents as they would be with the incoming row merged in
    always_comb begin
        beat_data      = asm_data;
        beat_rv        = asm_rv;
        beat_data[cnt] = row;
        beat_rv[cnt]   = 1'b1;
    end

    assign new_entry = {in_last, in_txn_info, beat_rv, beat_data};

    // Assembly register: accumulate rows, clear when the beat is handed off
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            asm_data <= '0;
            asm_rv   <= '0;
            cnt      <= '0;
        end else if (acc) begin
            if (close) begin
                asm_data <= '0;
                asm_rv   <= '0;
                cnt      <= '0;
            end else begin
                asm_data <= beat_data;
                asm_rv   <= beat_rv;
                cnt      <= cnt + 1'b1;
            end
        end
    end

    // Two-entry FIFO with q0 as the head; outputs come straight from q0
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            q0    <= '0;
            q1    <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q0 <= new_entry;
                    end else begin
                        q1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    q0 <= new_entry;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready      = (count != 2'd2);
    assign out_valid     = (count != 2'd0);
    assign out_data      = q0[BW_OUT-1:0];
    assign out_row_valid = q0[BW_OUT +: ROWS_PER_BEAT];
    assign out_txn_info  = q0[BW_OUT+ROWS_PER_BEAT +: BW_TXN_INFO];
    assign out_last      = q0[EW-1];
    assign busy          = (|asm_rv) || out_valid;

endmodule
